// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared opcodes, FSM states and flag bundle for the sequenced ALU.
//   op_e    : 3-bit opcode encoding (NAND/ADD/SUB keep the legacy ALU codes)
//   state_e : controller states
//   flags_t : packed {zero, carry, negative, overflow}
package alu_seq_pkg;

    typedef enum logic [2:0] {
        OP_NAND = 3'b000,
        OP_ADD  = 3'b001,
        OP_AND  = 3'b010,
        OP_SUB  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_SHL  = 3'b110,
        OP_MUL  = 3'b111
    } op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } flags_t;

    localparam flags_t FLAGS_RESET = '{zero: 1'b1, carry: 1'b0, negative: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu_seq_core.sv
// alu_core: combinational single-cycle operations and their flags.
//   op     : opcode (MUL is not handled here; yields 0)
//   a, b   : operands
//   result : op result, modulo 2^WIDTH
//   flags  : zero/carry/negative/overflow for result
module alu_core
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output flags_t           flags
);

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // ADD and SUB share one adder; SUB is A + ~B + 1, so carry-out means no borrow.
    always_comb begin
        is_sub = (op_e'(op) == OP_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        result = '0;
        flags  = '0;
        case (op_e'(op))
            OP_NAND: result = ~(a & b);
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ADD, OP_SUB: begin
                result         = sum[WIDTH-1:0];
                flags.carry    = sum[WIDTH];
                flags.overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: begin
                result      = {a[WIDTH-2:0], 1'b0};
                flags.carry = a[WIDTH-1];
            end
            default: result = '0;
        endcase
        flags.zero     = (result == '0);
        flags.negative = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes, accumulator operand
// path and a multi-cycle shift-add unsigned multiply.
//   clk, rst             : clock, async active-high reset
//   in_valid / in_ready  : request handshake (op, use_acc, a, b sampled on accept)
//   out_valid / out_ready: result handshake
//   result               : registered result, also the accumulator
//   zero/carry/negative/overflow : registered flags
//
// state  | meaning
// S_IDLE | accepts requests; single-cycle ops complete on the accept edge
// S_MUL  | shift-add multiply, one partial product per edge, WIDTH edges
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             negative,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    flags_t             flags_q;
    logic [2*WIDTH-1:0] mcand_q, prod_q, prod_next;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      iter_q;
    logic               accept, mul_done;
    logic [WIDTH-1:0]   opa, core_result;
    flags_t             core_flags, mul_flags;

    assign in_ready  = (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    // Accumulator reads the register as it stands this cycle, even if it is being drained.
    assign opa       = use_acc ? result_q : a;
    assign prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_done  = (state_q == S_MUL) && (iter_q == LAST_ITER);

    always_comb begin
        mul_flags          = '0;
        mul_flags.zero     = (prod_next[WIDTH-1:0] == '0);
        mul_flags.negative = prod_next[WIDTH-1];
        mul_flags.carry    = |prod_next[2*WIDTH-1:WIDTH];
    end

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (op),
        .a      (opa),
        .b      (b),
        .result (core_result),
        .flags  (core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && op_e'(op) == OP_MUL) state_d = S_MUL;
            S_MUL:   if (mul_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= FLAGS_RESET;
            mcand_q     <= '0;
            prod_q      <= '0;
            mplier_q    <= '0;
            iter_q      <= '0;
        end else if (accept) begin
            if (op_e'(op) == OP_MUL) begin
                mcand_q     <= {{WIDTH{1'b0}}, opa};
                mplier_q    <= b;
                prod_q      <= '0;
                iter_q      <= '0;
                // Acceptance implies any pending result is drained this edge.
                out_valid_q <= 1'b0;
            end else begin
                result_q    <= core_result;
                flags_q     <= core_flags;
                out_valid_q <= 1'b1;
            end
        end else if (state_q == S_MUL) begin
            prod_q   <= prod_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            iter_q   <= iter_q + CW'(1);
            if (mul_done) begin
                result_q    <= prod_next[WIDTH-1:0];
                flags_q     <= mul_flags;
                out_valid_q <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = flags_q.zero;
    assign carry     = flags_q.carry;
    assign negative  = flags_q.negative;
    assign overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b000;
    logic         use_acc = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero, carry, negative, overflow;

    int total = 0;
    int bad = 0;
    logic [W-1:0] m_res = '0;
    logic [3:0]   m_flags = 4'b1000;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .use_acc   (use_acc),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .negative  (negative),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference: returns {result[3:0], zero, carry, negative, overflow} from plain integer arithmetic.
    function automatic logic [7:0] ref_op(input logic [2:0] o, input int av, input int bv);
        int res, c, v, sa, sb, ss, p;
        res = 0; c = 0; v = 0;
        sa = (av > 7) ? av - 16 : av;
        sb = (bv > 7) ? bv - 16 : bv;
        case (o)
            3'b000: res = (~(av & bv)) & 15;
            3'b001: begin
                res = (av + bv) % 16; c = (av + bv > 15) ? 1 : 0;
                ss = sa + sb; v = (ss > 7 || ss < -8) ? 1 : 0;
            end
            3'b010: res = av & bv;
            3'b011: begin
                res = (av - bv + 16) % 16; c = (av >= bv) ? 1 : 0;
                ss = sa - sb; v = (ss > 7 || ss < -8) ? 1 : 0;
            end
            3'b100: res = av | bv;
            3'b101: res = av ^ bv;
            3'b110: begin res = (av * 2) % 16; c = (av >= 8) ? 1 : 0; end
            default: begin p = av * bv; res = p % 16; c = (p >= 16) ? 1 : 0; end
        endcase
        return {res[3:0], (res == 0), c[0], (res >= 8), v[0]};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag);
        check({tag, "_res"}, {4'h0, result}, {4'h0, m_res});
        check({tag, "_flg"}, {4'h0, zero, carry, negative, overflow}, {4'h0, m_flags});
    endtask

    // Issue one request with out_ready high and check it against the model.
    // During MUL, in_valid stays high with scrambled inputs to confirm they are ignored.
    task automatic do_op(input logic [2:0] o, input logic ua, input logic [W-1:0] av,
                         input logic [W-1:0] bv, input string tag);
        logic [7:0] e;
        e = ref_op(o, ua ? int'(m_res) : int'(av), int'(bv));
        op = o; use_acc = ua; a = av; b = bv; in_valid = 1'b1;
        check({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        tick();
        if (o == 3'b111) begin
            op = 3'b001; a = 4'h0; b = 4'h0; use_acc = 1'b0;
            for (int i = 0; i < W; i++) begin
                check({tag, "_busy_rdy"}, {7'd0, in_ready}, 8'd0);
                check({tag, "_busy_ov"}, {7'd0, out_valid}, 8'd0);
                check({tag, "_busy_res"}, {4'h0, result}, {4'h0, m_res});
                tick();
            end
        end
        in_valid = 1'b0;
        m_res = e[7:4];
        m_flags = e[3:0];
        check({tag, "_ov"}, {7'd0, out_valid}, 8'd1);
        check_out(tag);
    endtask

    initial begin
        // Reset: asynchronous, observed before any clock edge
        #2 rst = 1'b1;
        #1;
        check("rst_res", {4'h0, result}, 8'h00);
        check("rst_flg", {4'h0, zero, carry, negative, overflow}, 8'h08);
        check("rst_ov", {7'd0, out_valid}, 8'd0);
        check("rst_rdy", {7'd0, in_ready}, 8'd1);
        #3 rst = 1'b0;
        tick();

        // ADD/SUB flag corners with absolute constants
        do_op(3'b001, 1'b0, 4'h7, 4'h1, "add_7_1");
        check("add_7_1_abs", {result, zero, carry, negative, overflow}, {4'h8, 4'b0011});
        do_op(3'b011, 1'b0, 4'h3, 4'h3, "sub_3_3");
        check("sub_3_3_abs", {result, zero, carry, negative, overflow}, {4'h0, 4'b1100});
        do_op(3'b011, 1'b0, 4'h2, 4'h3, "sub_2_3");
        check("sub_2_3_abs", {result, zero, carry, negative, overflow}, {4'hF, 4'b0010});

        // Logic, shift, back-to-back accumulate
        do_op(3'b000, 1'b0, 4'hF, 4'hF, "nand_ff");
        check("nand_ff_abs", {result, zero}, {4'h0, 1'b1});
        do_op(3'b110, 1'b0, 4'h9, 4'h0, "shl_9");
        check("shl_9_abs", {result, carry}, {4'h2, 1'b1});
        do_op(3'b001, 1'b0, 4'h2, 4'h3, "add_2_3");
        check("add_2_3_abs", {4'h0, result}, 8'h05);
        do_op(3'b001, 1'b1, 4'h0, 4'h5, "acc_add_5");
        check("acc_add_5_abs", {4'h0, result}, 8'h0A);

        // MUL
        do_op(3'b111, 1'b0, 4'h5, 4'h3, "mul_5_3");
        check("mul_5_3_abs", {result, carry}, {4'hF, 1'b0});
        do_op(3'b111, 1'b0, 4'h6, 4'h3, "mul_6_3");
        check("mul_6_3_abs", {result, carry}, {4'h2, 1'b1});

        // Drain without a new request: out_valid clears, result held
        tick();
        check("drain_ov", {7'd0, out_valid}, 8'd0);
        check_out("drain");

        // Backpressure
        do_op(3'b001, 1'b0, 4'h4, 4'h5, "bp_add");
        out_ready = 1'b0;
        op = 3'b001; use_acc = 1'b0; a = 4'h1; b = 4'h1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rdy", {7'd0, in_ready}, 8'd0);
            check("bp_ov", {7'd0, out_valid}, 8'd1);
            check_out("bp_hold");
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {7'd0, in_ready}, 8'd1);
        tick();
        in_valid = 1'b0;
        m_res = 4'h2; m_flags = 4'b0000;
        check("bp_accept_ov", {7'd0, out_valid}, 8'd1);
        check_out("bp_accept");

        // Random ops against the model, accumulator included
        for (int n = 0; n < 40; n++) begin
            do_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd");
        end

        // Reset mid-MUL after two iterations
        op = 3'b111; use_acc = 1'b0; a = 4'h7; b = 4'h7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("rmul_ov", {7'd0, out_valid}, 8'd0);
        check("rmul_res", {4'h0, result}, 8'h00);
        check("rmul_rdy", {7'd0, in_ready}, 8'd1);
        #1 rst = 1'b0;
        m_res = 4'h0; m_flags = 4'b1000;
        tick();
        check("rmul_idle_rdy", {7'd0, in_ready}, 8'd1);
        check("rmul_idle_ov", {7'd0, out_valid}, 8'd0);
        do_op(3'b001, 1'b0, 4'h1, 4'h1, "post_rst_add");
        check("post_rst_add_abs", {4'h0, result}, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 4-bit NAND/ADD/SUB ALU with a zero flag. It keeps that opcode sense for NAND/ADD/SUB and adds AND/OR/XOR/SHL and a multi-cycle unsigned multiply. It also adds full flags (Z/C/N/V), an accumulator operand path and valid/ready handshakes on input and output. It sits between the operand source and the result/LED consumer as the datapath's single arithmetic unit.

## Interface
- WIDTH, 4, operand/result width; legal values ≥ 2.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block accepts the request this cycle.
- op  in  3  opcode: 000 NAND, 001 ADD, 010 AND, 011 SUB, 100 OR, 101 XOR, 110 SHL, 111 MUL.
- use_acc  in  1  1: operand A is the current result register; 0: operand A is `a`.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  registered result; also serves as the accumulator.
- zero, carry, negative, overflow  out  1 each  registered flags.

## Operation
- **Accept.** A request is accepted on an edge where in_valid && in_ready. Operands, op and use_acc are sampled at that edge.
- **in_ready.** in_ready = (state == IDLE) && (!out_valid || out_ready). It is combinational and never depends on in_valid.
- **States.**
  - IDLE → IDLE on acceptance of a non-MUL op.
  - IDLE → MUL on acceptance of op 111.
  - MUL → IDLE after WIDTH iterations.
- **Arithmetic.** All arithmetic is modulo 2^WIDTH.
  - ADD: A+B.
  - SUB: A+~B+1.
  - SHL: {A[WIDTH-2:0],0}.
  - MUL: unsigned shift-add, one partial product per cycle, low WIDTH bits kept.
- **Flags.**
  - zero = (result == 0).
  - negative = result[WIDTH-1].
  - carry:
    - ADD/SUB: adder carry-out (SUB: 1 = no borrow).
    - SHL: A[WIDTH-1].
    - MUL: 1 iff the high WIDTH bits of the product are nonzero.
    - Logic ops: 0.
  - overflow: signed overflow for ADD/SUB; 0 for all other ops.
- **Accumulator.** result doubles as the accumulator. use_acc reads the result register value present in the acceptance cycle, including a value being drained that same cycle.
- **Output hold.** While out_valid && !out_ready, result and flags are held stable and no request is accepted.
- **Output register update.** result and flags change only when a new result is written; a drain alone does not change them. out_valid clears on an edge with out_ready and no new result written.
- **MUL internals.** Product and multiplier shift registers are internal. result is not modified until MUL completes.
- **Ignored inputs.** in_valid is ignored in MUL state (in_ready = 0).
- **Reset.** Reset at any time, including mid-MUL, aborts the operation and returns to IDLE.
  - Reset values: result = 0, zero = 1, carry = negative = overflow = 0, out_valid = 0, accumulator = 0.
  - in_ready is 1 after reset.

## Timing
- Non-MUL op accepted at edge k: result, flags and out_valid are visible after edge k.
- Throughput is one op per cycle when out_ready stays high (back-to-back acceptance while out_valid).
- MUL accepted at edge k:
  - Iterations run on edges k+1 … k+WIDTH.
  - result, flags and out_valid = 1 are visible after edge k+WIDTH.
  - in_ready = 0 from after edge k until after edge k+WIDTH.
- Acceptance of a MUL while out_valid && out_ready: out_valid = 0 after edge k.
- Iteration counter width: $clog2(WIDTH+1).

## Structure
- Package alu_seq_pkg:
  - opcode localparams/enum (OP_NAND … OP_MUL);
  - state enum (S_IDLE, S_MUL);
  - packed flags struct {zero, carry, negative, overflow}.
- Sub-module alu_core: combinational single-cycle ops and flag generation. It is parametrised by WIDTH.
- The top holds the FSM, MUL shift-add datapath, handshakes and output/accumulator registers.

## Test plan
All scenarios use WIDTH = 4.
- **Reset.** Pulse rst asynchronously mid-cycle → immediately result = 0, zero = 1, carry/negative/overflow = 0, out_valid = 0; in_ready = 1.
- **ADD/SUB flags.**
  - ADD 7+1 → result 8, negative = 1, overflow = 1, carry = 0, out_valid after 1 edge.
  - SUB 3−3 → result 0, zero = 1, carry = 1.
  - SUB 2−3 → result F, carry = 0, negative = 1.
- **Logic, shift and accumulator, out_ready = 1.**
  - NAND F,F → 0, zero = 1.
  - SHL 9 → 2, carry = 1.
  - ADD 2+3 then ADD use_acc = 1, b = 5 on consecutive edges → results 5 then A, one per cycle.
- **MUL.**
  - 5×3 → 15, carry = 0, out_valid exactly 4 edges after acceptance.
  - 6×3 → 2, carry = 1.
  - in_valid held high during MUL → no acceptance, in_ready = 0.
- **Backpressure.** out_ready = 0 for 5 cycles after a result → result and flags stable, in_ready = 0. Raising out_ready lets a pending request be accepted on the same edge.
- **Reset mid-MUL.** Assert rst at iteration 2 → S_IDLE, out_valid = 0, result = 0. Next ADD 1+1 → 2 normally.
